// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: latches and masks request lines, then walks one
// request at a time through assert -> acknowledge -> MRET towards the core.
module irq_arbiter #(
  parameter int               N_SRC     = 8,
  parameter logic [N_SRC-1:0] EDGE_MASK = {N_SRC{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src_i,
  input  logic [N_SRC-1:0] irq_en_i,
  input  logic             global_interrupt_en_i,
  input  logic             irq_ack_i,
  input  logic             irq_done_i,
  output logic             irq_valid_o,
  output logic [31:0]      irq_flag_o,
  output logic [4:0]       irq_id_o,
  output logic [N_SRC-1:0] pending_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SERVICE
  } state_t;

  state_t           r_state;
  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_pending;
  logic             r_valid;
  logic [31:0]      r_flag;
  logic [4:0]       r_id;
  logic             r_busy;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_svc;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_pending_nxt;
  logic [N_SRC-1:0] w_eligible;
  logic [4:0]       w_win_id;
  logic             w_win_en;

  always_comb begin
    // NOTE: every signal gets a value before any loop or condition, so no latch is inferred.
    w_rise   = irq_src_i & ~r_src_q;
    w_svc    = '0;
    w_win_id = '0;
    // The latched winner masks its own level line from the ack edge until it returns to IDLE.
    for (int i = 0; i < N_SRC; i++) begin
      w_svc[i] = (r_state != ST_IDLE) && (r_id == 5'(i + 1));
    end
    w_set         = (EDGE_MASK & w_rise) | (~EDGE_MASK & irq_src_i & ~w_svc);
    w_clr         = w_svc & {N_SRC{(r_state == ST_ASSERT) && irq_ack_i}};
    w_pending_nxt = (r_pending & ~w_clr) | w_set;
    w_eligible    = r_pending & irq_en_i;
    // Scan downwards so the lowest eligible index is the last (winning) assignment.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_win_id = 5'(i + 1);
    end
    w_win_en = |(irq_en_i & w_svc);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_src_q   <= '0;
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_flag    <= '0;
      r_id      <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_src_q   <= irq_src_i;
      r_pending <= w_pending_nxt;
      case (r_state)
        ST_IDLE: begin
          if (global_interrupt_en_i && (w_eligible != '0)) begin
            r_state <= ST_ASSERT;
            r_id    <= w_win_id;
            r_valid <= 1'b1;
            r_flag  <= 32'd1 << w_win_id;
            r_busy  <= 1'b1;
          end
        end
        ST_ASSERT: begin
          // Acknowledge beats withdraw; a higher-priority arrival never replaces the ID.
          if (irq_ack_i) begin
            r_state <= ST_SERVICE;
            r_valid <= 1'b0;
            r_flag  <= '0;
          end else if (!global_interrupt_en_i || !w_win_en) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_flag  <= '0;
            r_id    <= '0;
            r_busy  <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (irq_done_i) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_flag  <= '0;
          r_id    <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign irq_valid_o = r_valid;
  assign irq_flag_o  = r_flag;
  assign irq_id_o    = r_id;
  assign pending_o   = r_pending;
  assign busy_o      = r_busy;

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Prioritised interrupt request arbiter that collects up to N_SRC external/peripheral interrupt lines, latches them as pending, masks them, and presents exactly one request at a time to the core's interrupt controller through interrupt_flag. It sequences each request through assert, acknowledge (trap entry) and completion (MRET), so only one interrupt is in service at a time. It sits between the SoC interrupt sources and the core's CLINT input.

## Interface
- N_SRC, 8, number of interrupt sources (1..31); source i has ID i+1; ID 0 means none
- EDGE_MASK, {N_SRC{1'b1}}, per-source sense: 1 = rising-edge, 0 = level-high
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- irq_src_i  in  N_SRC  raw interrupt lines, synchronous to clk
- irq_en_i  in  N_SRC  per-source enable mask
- global_interrupt_en_i  in  1  global enable (mstatus.MIE)
- irq_ack_i  in  1  core has taken the asserted interrupt (trap entry), 1-cycle pulse
- irq_done_i  in  1  core executed MRET for the in-service interrupt, 1-cycle pulse
- irq_valid_o  out  1  request asserted to core
- irq_flag_o  out  32  one-hot: bit ID set while irq_valid_o=1, else 0
- irq_id_o  out  5  ID of asserted or in-service source, 0 in IDLE
- pending_o  out  N_SRC  pending register
- busy_o  out  1  state != IDLE

## Operation
- Edge detect: src_q register holds previous irq_src_i (reset 0); rise = irq_src_i & ~src_q. A source high at reset release counts as an edge.
- Pending set: edge sources on rise; level sources while high and not the in-service source. Pending clear: winner's bit on irq_ack_i. Set and clear same cycle on same bit: set wins.
- Eligible = pending & irq_en_i; winner = lowest-index eligible bit (fixed priority).
- FSM states IDLE, ASSERT, SERVICE (registered, one-hot encoding permitted):
  - IDLE: if global_interrupt_en_i and eligible != 0 -> latch winner ID, go ASSERT.
  - ASSERT: irq_valid_o=1, ID held fixed (a higher-priority arrival does not pre-empt). irq_ack_i -> clear winner pending, go SERVICE. Else if global_interrupt_en_i=0 or winner's irq_en_i=0 -> withdraw to IDLE, pending kept. ack and withdraw same cycle: ack wins.
  - SERVICE: irq_valid_o=0, irq_id_o holds ID. irq_done_i -> IDLE. No nesting.
- irq_ack_i outside ASSERT and irq_done_i outside SERVICE are ignored.
- Pending accumulates in all states; repeated edges on an already-pending source collapse into one.

## Timing
- Reset: state IDLE; irq_valid_o=0, irq_flag_o=0, irq_id_o=0, pending_o=0, busy_o=0, src_q=0.
- All outputs registered. irq_src_i rises at edge k -> pending bit 1 after edge k -> irq_valid_o/irq_flag_o 1 after edge k+1 (2-cycle latency, from IDLE with enables set).
- irq_ack_i sampled at edge a -> irq_valid_o=0, pending bit 0 after edge a.
- irq_done_i at edge d -> IDLE after d; next eligible request asserted after d+1.
- Withdraw: enable drop sampled at edge w -> irq_valid_o=0 after w.
- Reset asserted mid-operation clears all state at next edge regardless of FSM state.

## Test plan
- Single edge source 3 (ID 4), all enabled: pulse irq_src_i[3] one cycle -> irq_valid_o=1 two edges later, irq_flag_o=32'h10, irq_id_o=4; ack -> valid 0, pending_o[3]=0; done -> busy_o=0.
- Priority: sources 5 and 1 rise same cycle -> ID 2 asserted first; after ack+done, ID 6 asserted one cycle later.
- Masking/withdraw: source 0 pending with irq_en_i[0]=0 -> no valid; set enable -> valid; clear global_interrupt_en_i before ack -> valid drops, pending_o[0] stays 1, reasserts when re-enabled.
- Level source (EDGE_MASK bit 2=0) held high through ack and done -> not re-pended during SERVICE; re-asserted after done; drop line -> no further request.
- Simultaneous: new edge on the winner source in same cycle as irq_ack_i -> pending bit remains 1, re-served after done; ack with enable drop same cycle -> SERVICE entered.
- Reset mid-SERVICE: rst_n=0 one cycle -> all outputs 0, spurious irq_done_i afterward ignored.
